button_repeat: RTL and testbench
================================

# button_repeat

Press/hold/auto-repeat classifier for front-panel buttons. It consumes a debounced button level and a one-cycle timebase tick, and emits single-cycle `press`, `rep` and `rel` events plus a `held` level and a saturating repeat count. It sits directly downstream of the debounce stage and replaces a bare rising-edge pulse wherever a held key must auto-repeat, such as cursor movement or scrolling.

## Interface

Parameters:
- `HOLD_TICKS`, default 200: ticks from press to the first `rep`. Legal range 1..2^`CNT_W`.
- `REPEAT_TICKS`, default 40: ticks between consecutive `rep` pulses. Legal range 1..2^`CNT_W`.
- `CNT_W`, default 8: width of the internal tick counter.

Ports:
- `clk`, in, 1: the only clock; all logic is on its rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `btn`, in, 1: debounced button level, 1 = pressed, synchronous to `clk`.
- `tick`, in, 1: timebase enable, high for one `clk` cycle per tick.
- `press`, out, 1: one-cycle pulse when a press is accepted.
- `rep`, out, 1: one-cycle auto-repeat pulse.
- `rel`, out, 1: one-cycle pulse on release.
- `held`, out, 1: high while the FSM is in WAIT or REPEAT.
- `rep_count`, out, 8: number of `rep` pulses in the current hold. Saturates at 255; cleared on `press`.

## Operation

General rules:
- All outputs are registered. Nothing is combinational from an input to an output.
- FSM states: IDLE, WAIT, REPEAT. There is one counter `cnt` of `CNT_W` bits.

IDLE:
- `btn`=1 → go to WAIT, `cnt`=0, `press`=1, `rep_count`=0.
- `tick` in the same cycle is ignored.
- A button held through reset therefore produces a `press` on the first cycle after reset is released.

WAIT:
- `btn`=0 → go to IDLE, `rel`=1, `cnt`=0. Release has priority over everything else in the same cycle.
- Otherwise, on `tick`:
  - if `cnt`==`HOLD_TICKS`-1 → go to REPEAT, `cnt`=0, `rep`=1, `rep_count`++ (saturating);
  - else `cnt`++.

REPEAT:
- `btn`=0 → go to IDLE, `rel`=1, `cnt`=0. Release has priority over everything else in the same cycle.
- Otherwise, on `tick`:
  - if `cnt`==`REPEAT_TICKS`-1 → `cnt`=0, `rep`=1, `rep_count`++ (saturating);
  - else `cnt`++.

Arithmetic and pulse rules:
- `cnt` compares use `CNT_W`-bit unsigned arithmetic.
- `cnt` never exceeds its limit minus 1, so it never wraps.
- `rep_count` holds at 255 once reached; it never wraps to 0.
- `rep_count` holds its value after release until the next `press`.
- `press`, `rep` and `rel` are mutually exclusive in any one cycle.
- Each pulse is high for exactly one cycle. They are never stretched.

Reset (`rst_n`=0 at a clock edge):
- Next state is IDLE, `cnt`=0, and all outputs are 0.
- This applies at any point, including mid-WAIT or mid-REPEAT.
- No `rel` is generated by reset.

## Timing

Latencies:
- Input sampled at edge k → output visible after edge k, stable through edge k+1.
- `btn` 0→1 sampled at edge k in IDLE → `press` and `held` high after edge k.
- The first `rep` follows the edge that samples the `HOLD_TICKS`-th `tick` after entry into WAIT. The tick sampled at the entry edge is excluded.
- Each subsequent `rep` follows every `REPEAT_TICKS`-th tick.
- `btn` 1→0 sampled at edge k → `rel`=1 and `held`=0 after edge k.

Throughput:
- `HOLD_TICKS`=`REPEAT_TICKS`=1 with `tick` held high → `rep` on every cycle after the `press` cycle.
- Minimum press-to-release spacing is one cycle. A one-cycle `btn` high yields `press` and then `rel` on consecutive cycles.

## Test plan

1. Reset with button held: `rst_n`=0 for 3 cycles, `btn`=1 → all outputs 0 during reset; `press`=1 in the first cycle after `rst_n`=1; `held`=1 thereafter.
2. Short press: `HOLD_TICKS`=4, `tick` every 10 cycles, `btn` high for 25 cycles → exactly 1 `press`, 0 `rep`, 1 `rel`; `held` high for 25 cycles; `rep_count`=0.
3. Long hold: `HOLD_TICKS`=4, `REPEAT_TICKS`=2, `tick` every 10 cycles, `btn` high across exactly 10 ticks → `rep` follows ticks 4, 6, 8 and 10; `rep_count`=4 after release; exactly 1 `rel`.
4. Simultaneous events: in WAIT with `cnt`=`HOLD_TICKS`-1, drive `btn`=0 and `tick`=1 on the same edge → `rel`=1, `rep`=0, state IDLE, `rep_count` unchanged.
5. Saturation: `HOLD_TICKS`=`REPEAT_TICKS`=1, `tick`=1 constantly, hold for 300 cycles → `rep` high on every cycle after `press`; `rep_count` reaches 255 and stays at 255.
6. Reset mid-REPEAT: assert `rst_n`=0 for 1 cycle while in REPEAT → `held`=0, `rel`=0, `rep_count`=0 next cycle; if `btn` is still 1, `press`=1 in the first cycle after release.

Source files
------------

// File: rtl/button_repeat.sv
// button_repeat: classifies a debounced button into press/auto-repeat/release events with a saturating repeat count
module button_repeat #(
  parameter int HOLD_TICKS = 200,
  parameter int REPEAT_TICKS = 40,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       tick,
  output logic       press,
  output logic       rep,
  output logic       rel,
  output logic       held,
  output logic [7:0] rep_count
);
  typedef enum logic [1:0] {IDLE, WAIT, REPEAT} state_t;
  localparam logic [CNT_W-1:0] hold_lim = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] rep_lim = CNT_W'(REPEAT_TICKS - 1);
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic press_d, rep_d, rel_d, hit;
  logic [7:0] rep_count_d;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    press_d = 1'b0;
    rep_d = 1'b0;
    rel_d = 1'b0;
    rep_count_d = rep_count;
    hit = cnt == (state == WAIT ? hold_lim : rep_lim);
    if (state == IDLE) begin
      if (btn) begin
        state_d = WAIT;
        cnt_d = '0;
        press_d = 1'b1;
        rep_count_d = '0;
      end
    end else if (!btn) begin
      state_d = IDLE;
      cnt_d = '0;
      rel_d = 1'b1;
    end else if (tick) begin
      if (hit) begin
        state_d = REPEAT;
        cnt_d = '0;
        rep_d = 1'b1;
        rep_count_d = &rep_count ? rep_count : rep_count + 8'd1;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      press <= 1'b0;
      rep <= 1'b0;
      rel <= 1'b0;
      held <= 1'b0;
      rep_count <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      press <= press_d;
      rep <= rep_d;
      rel <= rel_d;
      held <= state_d != IDLE;
      rep_count <= rep_count_d;
    end
  end
endmodule

// File: tb/tb_button_repeat.sv
// tb_button_repeat: scoreboard bench for button_repeat with hand-computed event timing
module tb_button_repeat;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] btn = '0;
  logic [1:0] tick = '0;
  logic [1:0] press, rep, rel, held;
  logic [7:0] rc_a, rc_b;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int d;
    int cyc;
    int kind;
    int rc;
  } ev_t;
  ev_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  button_repeat #(.HOLD_TICKS(4), .REPEAT_TICKS(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn(btn[0]), .tick(tick[0]),
    .press(press[0]), .rep(rep[0]), .rel(rel[0]), .held(held[0]), .rep_count(rc_a)
  );
  button_repeat #(.HOLD_TICKS(1), .REPEAT_TICKS(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn(btn[1]), .tick(tick[1]),
    .press(press[1]), .rep(rep[1]), .rel(rel[1]), .held(held[1]), .rep_count(rc_b)
  );
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic exp_ev(input int d, input int kind, input int rc);
    q.push_back(ev_t'{d, cyc + 1, kind, rc});
  endtask
  task automatic step(input int d, input logic b, input logic t);
    btn = '0;
    tick = '0;
    btn[d] = b;
    tick[d] = t;
    @(negedge clk);
  endtask
  initial begin
    logic [2:0] p;
    int kind, rc;
    ev_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        p = {rel[d], rep[d], press[d]};
        if (p != 3'b000) begin
          kind = p[0] ? 0 : p[1] ? 1 : 2;
          rc = d == 1 ? int'(rc_b) : int'(rc_a);
          if ($countones(p) > 1) begin
            checks++;
            errors++;
            $display("FAIL exclusive: dut %0d pulses %b at cycle %0d, required one-hot", d, p, cyc);
          end else if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: dut %0d kind %0d at cycle %0d, required none", d, kind, cyc);
          end else begin
            e = q.pop_front();
            chk("ev_dut", d, e.d);
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_kind", kind, e.kind);
            chk("ev_rep_count", rc, e.rc);
            chk("ev_held", int'(held[d]), e.kind != 2 ? 1 : 0);
          end
        end
      end
    end
  end
  initial begin
    int hcnt, r;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b1, 1'b0);
      chk("rst_pulses", int'({press[0], rep[0], rel[0], held[0]}), 0);
      chk("rst_rep_count", int'(rc_a), 0);
    end
    rst_n = 1'b1;
    exp_ev(0, 0, 0);
    step(0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b0);
    chk("held_after_rst", int'(held[0]), 1);
    exp_ev(0, 2, 0);
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    hcnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 0) exp_ev(0, 0, 0);
      step(0, 1'b1, i % 10 == 9);
      hcnt += int'(held[0]);
    end
    exp_ev(0, 2, 0);
    step(0, 1'b0, 1'b0);
    hcnt += int'(held[0]);
    chk("short_held_cycles", hcnt, 25);
    chk("short_rep_count", int'(rc_a), 0);
    r = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 0) exp_ev(0, 0, 0);
      if (i == 39 || i == 59 || i == 79 || i == 99) begin
        r++;
        exp_ev(0, 1, r);
      end
      step(0, 1'b1, i % 10 == 9);
    end
    exp_ev(0, 2, 4);
    step(0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0);
    chk("long_rc_after_release", int'(rc_a), 4);
    exp_ev(0, 0, 0);
    step(0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b1);
    exp_ev(0, 2, 0);
    step(0, 1'b0, 1'b1);
    chk("simul_held", int'(held[0]), 0);
    step(0, 1'b0, 1'b1);
    chk("simul_idle_held", int'(held[0]), 0);
    chk("simul_rep_count", int'(rc_a), 0);
    exp_ev(0, 0, 0);
    step(0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) exp_ev(0, 1, 1);
      if (i == 5) exp_ev(0, 1, 2);
      step(0, 1'b1, 1'b1);
    end
    rst_n = 1'b0;
    step(0, 1'b1, 1'b1);
    chk("midrst_held", int'(held[0]), 0);
    chk("midrst_rel", int'(rel[0]), 0);
    chk("midrst_press", int'(press[0]), 0);
    chk("midrst_rep_count", int'(rc_a), 0);
    rst_n = 1'b1;
    exp_ev(0, 0, 0);
    step(0, 1'b1, 1'b0);
    exp_ev(0, 2, 0);
    step(0, 1'b0, 1'b0);
    exp_ev(1, 0, 0);
    step(1, 1'b1, 1'b1);
    for (int i = 1; i < 300; i++) begin
      exp_ev(1, 1, i < 255 ? i : 255);
      step(1, 1'b1, 1'b1);
    end
    exp_ev(1, 2, 255);
    step(1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1, 1'b0, 1'b1);
    chk("sat_rc_after_release", int'(rc_b), 255);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
